// File: rtl/sel_stepper_pkg.sv
// Shared helpers for select-to-value lookups: table/default mapping and
// index stepping with wrap or saturate behaviour at the range ends.
package sel_stepper_pkg;

  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_UP   = 2'd1,
    STEP_DOWN = 2'd2,
    STEP_LOAD = 2'd3
  } step_op_e;

  // Table value for an index; the caller truncates to its output width.
  function automatic int unsigned sel_to_val(
    input int unsigned idx,
    input int unsigned n_entries,
    input int unsigned offset,
    input int unsigned default_val
  );
    if (idx < n_entries) return idx + offset;
    return default_val;
  endfunction

  // One step up (up=1) or down (up=0). Out-of-range indices re-enter at
  // the end nearest the direction of travel.
  function automatic int unsigned step_idx(
    input int unsigned idx,
    input logic        up,
    input int unsigned n_entries,
    input logic        wrap
  );
    if (up) begin
      if (idx >= n_entries)      return 0;
      if (idx == n_entries - 1)  return wrap ? 0 : idx;
      return idx + 1;
    end
    if (idx >= n_entries)        return n_entries - 1;
    if (idx == 0)                return wrap ? n_entries - 1 : 0;
    return idx - 1;
  endfunction

endpackage

// File: rtl/sel_stepper_step_pulse_gen.sv
// Rising-edge pulse from a level input, with optional hold-to-repeat.
// The repeat timer is a down-counter: it is loaded on every pulse and a
// repeat pulse fires when it reaches zero while the level is still held.
module step_pulse_gen #(
  parameter int unsigned REPEAT_CYC = 0
) (
  input  logic Clk_i,
  input  logic Rst_i,
  input  logic Lvl_i,
  output logic Pulse_o
);

  logic lvl_q;
  logic rise;

  assign rise = Lvl_i & ~lvl_q;

  // Level history for edge detection.
  always_ff @(posedge Clk_i) begin
    if (Rst_i) lvl_q <= 1'b0;
    else       lvl_q <= Lvl_i;
  end

  generate
    if (REPEAT_CYC == 0) begin : g_norep
      assign Pulse_o = rise;
    end else begin : g_rep
      localparam int unsigned CNT_W = (REPEAT_CYC > 1) ? $clog2(REPEAT_CYC) : 1;

      logic [CNT_W-1:0] cnt_q;
      logic             rep;

      assign rep     = Lvl_i & lvl_q & (cnt_q == '0);
      assign Pulse_o = rise | rep;

      // Repeat timer: reload on each pulse, clear when the input drops.
      always_ff @(posedge Clk_i) begin
        if (Rst_i)              cnt_q <= '0;
        else if (!Lvl_i)        cnt_q <= '0;
        else if (rise || rep)   cnt_q <= CNT_W'(REPEAT_CYC - 1);
        else                    cnt_q <= cnt_q - 1'b1;
      end
    end
  endgenerate

endmodule

// File: rtl/sel_stepper.sv
// Selection index stepper: button-driven up/down/load of an index with a
// registered table value. Y_o/Valid_o are derived from the next index so
// they never lag Sel_o.
module sel_stepper #(
  parameter int unsigned SEL_W       = 4,
  parameter int unsigned OUT_W       = 4,
  parameter int unsigned N_ENTRIES   = 10,
  parameter int unsigned OFFSET      = 1,
  parameter int unsigned DEFAULT_VAL = 5,
  parameter int unsigned RESET_SEL   = 0,
  parameter bit          WRAP        = 1'b1,
  parameter int unsigned REPEAT_CYC  = 0
) (
  input  logic             Clk_i,
  input  logic             Rst_i,
  input  logic             Up_i,
  input  logic             Down_i,
  input  logic             Load_i,
  input  logic [SEL_W-1:0] LoadSel_i,
  output logic [SEL_W-1:0] Sel_o,
  output logic [OUT_W-1:0] Y_o,
  output logic             Valid_o,
  output logic             Change_o
);

  import sel_stepper_pkg::*;

  logic             up_pulse;
  logic             down_pulse;
  step_op_e         op;
  logic [SEL_W-1:0] sel_q;
  logic [SEL_W-1:0] sel_nxt;
  logic [OUT_W-1:0] y_q;
  logic             valid_q;
  logic             chg_q;

  step_pulse_gen #(.REPEAT_CYC(REPEAT_CYC)) u_up_pulse (
    .Clk_i   (Clk_i),
    .Rst_i   (Rst_i),
    .Lvl_i   (Up_i),
    .Pulse_o (up_pulse)
  );

  step_pulse_gen #(.REPEAT_CYC(REPEAT_CYC)) u_down_pulse (
    .Clk_i   (Clk_i),
    .Rst_i   (Rst_i),
    .Lvl_i   (Down_i),
    .Pulse_o (down_pulse)
  );

  // Priority: load, then opposing steps cancel, then up, then down.
  always_comb begin
    op = STEP_NONE;
    if (Load_i)                      op = STEP_LOAD;
    else if (up_pulse && down_pulse) op = STEP_NONE;
    else if (up_pulse)               op = STEP_UP;
    else if (down_pulse)             op = STEP_DOWN;
  end

  // Next index from the selected operation.
  always_comb begin
    sel_nxt = sel_q;
    case (op)
      STEP_LOAD: sel_nxt = LoadSel_i;
      STEP_UP:   sel_nxt = SEL_W'(step_idx(32'(sel_q), 1'b1, N_ENTRIES, WRAP));
      STEP_DOWN: sel_nxt = SEL_W'(step_idx(32'(sel_q), 1'b0, N_ENTRIES, WRAP));
      default:   sel_nxt = sel_q;
    endcase
  end

  // Index, table value, validity and change-pulse registers.
  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      sel_q   <= SEL_W'(RESET_SEL);
      y_q     <= OUT_W'(sel_to_val(RESET_SEL, N_ENTRIES, OFFSET, DEFAULT_VAL));
      valid_q <= 1'b1;
      chg_q   <= 1'b0;
    end else begin
      sel_q   <= sel_nxt;
      y_q     <= OUT_W'(sel_to_val(32'(sel_nxt), N_ENTRIES, OFFSET, DEFAULT_VAL));
      valid_q <= (32'(sel_nxt) < N_ENTRIES);
      chg_q   <= (sel_nxt != sel_q);
    end
  end

  assign Sel_o    = sel_q;
  assign Y_o      = y_q;
  assign Valid_o  = valid_q;
  assign Change_o = chg_q;

endmodule

// File: tb/tb_sel_stepper.sv
// Bench for sel_stepper: a wrapping/no-repeat instance (a) and a
// saturating/repeat-4 instance (b) share one stimulus stream. A
// hold-count reference model predicts both every cycle; directed steps
// also check fixed expected values.
module tb_sel_stepper;

  logic       clk = 1'b0;
  logic       rst, up, down, load;
  logic [3:0] load_sel;
  logic [3:0] sel_a, y_a, sel_b, y_b;
  logic       valid_a, chg_a, valid_b, chg_b;

  int checks = 0;
  int errors = 0;

  localparam int N    = 10;
  localparam int OFFS = 1;
  localparam int DEFV = 5;

  int m_idx[2];
  int m_hu[2];
  int m_hd[2];
  bit m_chg[2];
  int m_rep[2]  = '{0, 4};
  bit m_wrap[2] = '{1'b1, 1'b0};

  always #5 clk = ~clk;

  sel_stepper dut_a (
    .Clk_i(clk), .Rst_i(rst), .Up_i(up), .Down_i(down), .Load_i(load),
    .LoadSel_i(load_sel), .Sel_o(sel_a), .Y_o(y_a), .Valid_o(valid_a),
    .Change_o(chg_a)
  );

  sel_stepper #(.WRAP(1'b0), .REPEAT_CYC(4)) dut_b (
    .Clk_i(clk), .Rst_i(rst), .Up_i(up), .Down_i(down), .Load_i(load),
    .LoadSel_i(load_sel), .Sel_o(sel_b), .Y_o(y_b), .Valid_o(valid_b),
    .Change_o(chg_b)
  );

  // A press registers on the first held cycle and every r held cycles after.
  function automatic bit pressed(input int h, input int r);
    return (h == 1) || (r > 0 && h > 1 && ((h - 1) % r) == 0);
  endfunction

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_idx[i] = 0; m_hu[i] = 0; m_hd[i] = 0; m_chg[i] = 1'b0;
      end else begin
        int  old;
        bit  pu, pd;
        m_hu[i] = up   ? m_hu[i] + 1 : 0;
        m_hd[i] = down ? m_hd[i] + 1 : 0;
        pu  = pressed(m_hu[i], m_rep[i]);
        pd  = pressed(m_hd[i], m_rep[i]);
        old = m_idx[i];
        if (load) m_idx[i] = int'(load_sel);
        else if (pu && pd) m_idx[i] = old;
        else if (pu) begin
          if (old >= N)         m_idx[i] = 0;
          else if (old == N-1)  m_idx[i] = m_wrap[i] ? 0 : old;
          else                  m_idx[i] = old + 1;
        end else if (pd) begin
          if (old >= N)         m_idx[i] = N - 1;
          else if (old == 0)    m_idx[i] = m_wrap[i] ? N - 1 : 0;
          else                  m_idx[i] = old - 1;
        end
        m_chg[i] = (m_idx[i] != old);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic compare_model();
    for (int i = 0; i < 2; i++) begin
      int ey;
      ey = (m_idx[i] < N) ? ((m_idx[i] + OFFS) % 16) : DEFV;
      chk(i == 0 ? "model_sel_a"   : "model_sel_b",   i == 0 ? 32'(sel_a)   : 32'(sel_b),   32'(m_idx[i]));
      chk(i == 0 ? "model_y_a"     : "model_y_b",     i == 0 ? 32'(y_a)     : 32'(y_b),     32'(ey));
      chk(i == 0 ? "model_valid_a" : "model_valid_b", i == 0 ? 32'(valid_a) : 32'(valid_b), 32'(m_idx[i] < N));
      chk(i == 0 ? "model_chg_a"   : "model_chg_b",   i == 0 ? 32'(chg_a)   : 32'(chg_b),   32'(m_chg[i]));
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_model();
  endtask

  task automatic drive(input logic r, input logic u, input logic d, input logic l, input logic [3:0] ls);
    rst = r; up = u; down = d; load = l; load_sel = ls;
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    cyc();
    chk("reset_sel",   32'(sel_a),   32'd0);
    chk("reset_y",     32'(y_a),     32'd1);
    chk("reset_valid", 32'(valid_a), 32'd1);
    chk("reset_chg",   32'(chg_a),   32'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    cyc();

    for (int k = 0; k < 9; k++) begin
      up = 1'b1; cyc();
      up = 1'b0; cyc();
    end
    chk("up9_y_a", 32'(y_a), 32'd10);
    chk("up9_y_b", 32'(y_b), 32'd10);

    up = 1'b1; cyc();
    chk("wrap_sel_a", 32'(sel_a), 32'd0);
    chk("wrap_y_a",   32'(y_a),   32'd1);
    chk("wrap_chg_a", 32'(chg_a), 32'd1);
    chk("sat_sel_b",  32'(sel_b), 32'd9);
    chk("sat_chg_b",  32'(chg_b), 32'd0);
    up = 1'b0; cyc();
    chk("chg_one_cycle", 32'(chg_a), 32'd0);

    rst = 1'b1; cyc(); rst = 1'b0;
    down = 1'b1; cyc();
    chk("down0_sel_b", 32'(sel_b), 32'd0);
    chk("down0_chg_b", 32'(chg_b), 32'd0);
    chk("down0_sel_a", 32'(sel_a), 32'd9);
    down = 1'b0; cyc();

    rst = 1'b1; cyc(); rst = 1'b0;
    up = 1'b1;
    for (int k = 0; k < 13; k++) cyc();
    chk("hold13_sel_a", 32'(sel_a), 32'd1);
    chk("hold13_sel_b", 32'(sel_b), 32'd4);
    for (int k = 0; k < 7; k++) cyc();
    chk("hold20_sel_a", 32'(sel_a), 32'd1);
    chk("hold20_sel_b", 32'(sel_b), 32'd5);
    up = 1'b0; cyc();

    drive(1'b0, 1'b0, 1'b0, 1'b1, 4'd12); cyc();
    chk("load12_y_a",     32'(y_a),     32'd5);
    chk("load12_valid_a", 32'(valid_a), 32'd0);
    chk("load12_y_b",     32'(y_b),     32'd5);
    chk("load12_valid_b", 32'(valid_b), 32'd0);
    load = 1'b0; up = 1'b1; cyc();
    chk("oor_up_sel_a", 32'(sel_a), 32'd0);
    chk("oor_up_y_a",   32'(y_a),   32'd1);
    chk("oor_up_sel_b", 32'(sel_b), 32'd0);
    up = 1'b0; cyc();
    load = 1'b1; cyc();
    load = 1'b0; down = 1'b1; cyc();
    chk("oor_dn_sel_a", 32'(sel_a), 32'd9);
    chk("oor_dn_y_a",   32'(y_a),   32'd10);
    chk("oor_dn_sel_b", 32'(sel_b), 32'd9);
    down = 1'b0; cyc();

    up = 1'b1; down = 1'b1; cyc();
    chk("both_sel_a", 32'(sel_a), 32'd9);
    chk("both_chg_a", 32'(chg_a), 32'd0);
    up = 1'b0; down = 1'b0; cyc();

    drive(1'b0, 1'b1, 1'b0, 1'b1, 4'd7); cyc();
    chk("load_wins_a", 32'(sel_a), 32'd7);
    chk("load_wins_b", 32'(sel_b), 32'd7);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0); cyc();

    up = 1'b1;
    for (int k = 0; k < 6; k++) cyc();
    rst = 1'b1; cyc();
    chk("rst_rep_sel_a", 32'(sel_a), 32'd0);
    chk("rst_rep_sel_b", 32'(sel_b), 32'd0);
    chk("rst_rep_chg_b", 32'(chg_b), 32'd0);
    rst = 1'b0; cyc();
    chk("rst_rel_sel_a", 32'(sel_a), 32'd1);
    chk("rst_rel_sel_b", 32'(sel_b), 32'd1);
    chk("rst_rel_chg_a", 32'(chg_a), 32'd1);
    up = 1'b0; cyc();

    for (int k = 0; k < 400; k++) begin
      rst      = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 3) == 0) up   = ~up;
      if ($urandom_range(0, 3) == 0) down = ~down;
      load     = ($urandom_range(0, 9) == 0);
      load_sel = 4'($urandom_range(0, 15));
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
